// File: rtl/ovsf_spreader_mc.sv
// Multi-channel OVSF spreader: each channel XORs a length-2^L OVSF code onto 1-bit
// symbols, one chip per chip_en strobe, with SF/K changes applied only on symbol boundaries.
module ovsf_spreader_mc #(
  parameter int NUM_CH = 4,
  parameter int MAX_L  = 9,
  parameter int LW     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chip_en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [LW-1:0]             cfg_l,
  input  logic [MAX_L-1:0]          cfg_k,
  output logic                      cfg_err,
  input  logic [NUM_CH-1:0]         sym_valid,
  input  logic [NUM_CH-1:0]         sym_data,
  output logic [NUM_CH-1:0]         sym_ready,
  output logic [NUM_CH-1:0]         chip_out,
  output logic [NUM_CH-1:0]         chip_vld,
  output logic [NUM_CH-1:0]         underrun
);

  logic [NUM_CH-1:0][LW-1:0]    cur_l_q,  cur_l_d;
  logic [NUM_CH-1:0][MAX_L-1:0] cur_k_q,  cur_k_d;
  logic [NUM_CH-1:0][LW-1:0]    pend_l_q, pend_l_d;
  logic [NUM_CH-1:0][MAX_L-1:0] pend_k_q, pend_k_d;
  logic [NUM_CH-1:0][MAX_L-1:0] cnt_q,    cnt_d;
  logic [NUM_CH-1:0]            pend_q,     pend_d;
  logic [NUM_CH-1:0]            active_q,   active_d;
  logic [NUM_CH-1:0]            cur_sym_q,  cur_sym_d;
  logic [NUM_CH-1:0]            nxt_q,      nxt_d;
  logic [NUM_CH-1:0]            nxt_full_q, nxt_full_d;
  logic [NUM_CH-1:0]            chip_out_q, chip_out_d;
  logic [NUM_CH-1:0]            chip_vld_q, chip_vld_d;
  logic [NUM_CH-1:0]            underrun_q, underrun_d;
  logic                         cfg_err_q,  cfg_err_d;

  logic cfg_accept;
  logic cfg_legal;

  // Bit-reversing all MAX_L bits and shifting right by (MAX_L-L) leaves exactly
  // rev_L(k[L-1:0]) in the low L bits with zeros above, so no variable indexing.
  function automatic logic code_chip(input logic [LW-1:0]    l,
                                     input logic [MAX_L-1:0] k,
                                     input logic [MAX_L-1:0] n);
    logic [MAX_L-1:0] rev;
    for (int unsigned i = 0; i < MAX_L; i++) rev[i] = k[MAX_L-1-i];
    rev = rev >> (LW'(MAX_L) - l);
    return ^(rev & n);
  endfunction

  assign cfg_ready  = ~pend_q[cfg_ch];
  assign cfg_accept = cfg_valid & cfg_ready;
  assign cfg_legal  = (cfg_l >= LW'(2)) && (cfg_l <= LW'(MAX_L));

  always_comb begin
    cur_l_d    = cur_l_q;
    cur_k_d    = cur_k_q;
    pend_l_d   = pend_l_q;
    pend_k_d   = pend_k_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    cur_sym_d  = cur_sym_q;
    nxt_d      = nxt_q;
    nxt_full_d = nxt_full_q;
    chip_out_d = chip_out_q;
    chip_vld_d = '0;
    underrun_d = '0;
    cfg_err_d  = cfg_accept & ~cfg_legal;

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      logic apply;
      apply = 1'b0;
      if (chip_en) begin
        if (active_q[c]) begin
          chip_out_d[c] = cur_sym_q[c] ^ code_chip(cur_l_q[c], cur_k_q[c], cnt_q[c]);
          chip_vld_d[c] = 1'b1;
          if (cnt_q[c] == ~({MAX_L{1'b1}} << cur_l_q[c])) begin
            cnt_d[c] = '0;
            apply    = 1'b1;
            if (nxt_full_q[c]) begin
              cur_sym_d[c]  = nxt_q[c];
              nxt_full_d[c] = 1'b0;
            end else begin
              active_d[c]   = 1'b0;
              underrun_d[c] = 1'b1;
            end
          end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end else if (nxt_full_q[c]) begin
          // Chip 0 of every OVSF code is +, so the emitted chip is the symbol itself.
          apply         = 1'b1;
          cur_sym_d[c]  = nxt_q[c];
          nxt_full_d[c] = 1'b0;
          active_d[c]   = 1'b1;
          chip_out_d[c] = nxt_q[c];
          chip_vld_d[c] = 1'b1;
          cnt_d[c]      = MAX_L'(1);
        end
      end

      if (apply && pend_q[c]) begin
        cur_l_d[c] = pend_l_q[c];
        cur_k_d[c] = pend_k_q[c];
        pend_d[c]  = 1'b0;
      end

      // Accepted only while pend is clear, so this never collides with the apply above.
      if (cfg_accept && cfg_legal && (cfg_ch == $clog2(NUM_CH)'(c))) begin
        pend_l_d[c] = cfg_l;
        pend_k_d[c] = cfg_k;
        pend_d[c]   = 1'b1;
      end

      if (sym_valid[c] && !nxt_full_q[c]) begin
        nxt_d[c]      = sym_data[c];
        nxt_full_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) cur_l_q[c] <= LW'(2);
      cur_k_q    <= '0;
      pend_l_q   <= '0;
      pend_k_q   <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      active_q   <= '0;
      cur_sym_q  <= '0;
      nxt_q      <= '0;
      nxt_full_q <= '0;
      chip_out_q <= '0;
      chip_vld_q <= '0;
      underrun_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cur_l_q    <= cur_l_d;
      cur_k_q    <= cur_k_d;
      pend_l_q   <= pend_l_d;
      pend_k_q   <= pend_k_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      cur_sym_q  <= cur_sym_d;
      nxt_q      <= nxt_d;
      nxt_full_q <= nxt_full_d;
      chip_out_q <= chip_out_d;
      chip_vld_q <= chip_vld_d;
      underrun_q <= underrun_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign sym_ready = ~nxt_full_q;
  assign chip_out  = chip_out_q;
  assign chip_vld  = chip_vld_q;
  assign underrun  = underrun_q;
  assign cfg_err   = cfg_err_q;

endmodule
